// File: rtl/risc16b_pkg.sv
// Shared encodings for the risc16b core: opcodes, R-format function codes,
// the instruction-field view, and small decode helpers.
package risc16b_pkg;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00100;
  localparam logic [4:0] OP_ANDI = 5'b00110;
  localparam logic [4:0] OP_ORI  = 5'b00111;
  localparam logic [4:0] OP_LLI  = 5'b01000;
  localparam logic [4:0] OP_LUI  = 5'b01001;
  localparam logic [4:0] OP_BNEZ = 5'b10000;
  localparam logic [4:0] OP_BEQZ = 5'b10001;
  localparam logic [4:0] OP_BMI  = 5'b10010;
  localparam logic [4:0] OP_BPL  = 5'b10011;
  localparam logic [4:0] OP_J    = 5'b11000;

  localparam logic [4:0] F_NOP = 5'b00000;
  localparam logic [4:0] F_MV  = 5'b00001;
  localparam logic [4:0] F_NOT = 5'b00010;
  localparam logic [4:0] F_XOR = 5'b00011;
  localparam logic [4:0] F_ADD = 5'b00100;
  localparam logic [4:0] F_SUB = 5'b00101;
  localparam logic [4:0] F_SL8 = 5'b01000;
  localparam logic [4:0] F_SR8 = 5'b01001;
  localparam logic [4:0] F_SL  = 5'b01100;
  localparam logic [4:0] F_SR  = 5'b01101;
  localparam logic [4:0] F_AND = 5'b10000;
  localparam logic [4:0] F_OR  = 5'b10001;
  localparam logic [4:0] F_ST  = 5'b10100;
  localparam logic [4:0] F_SB  = 5'b10101;
  localparam logic [4:0] F_LD  = 5'b10110;
  localparam logic [4:0] F_LBU = 5'b10111;

  localparam logic [15:0] NOP_INSN = 16'h0000;

  // I-format shares this layout; its imm8 is {rs, func}.
  typedef struct packed {
    logic [4:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [4:0] func;
  } insn_t;

  function automatic logic writes_reg(input logic [15:0] ir);
    logic wr;
    wr = 1'b0;
    casez (ir)
      16'b00000_???_???_00001, 16'b00000_???_???_00010,
      16'b00000_???_???_00011, 16'b00000_???_???_00100,
      16'b00000_???_???_00101, 16'b00000_???_???_01000,
      16'b00000_???_???_01001, 16'b00000_???_???_01100,
      16'b00000_???_???_01101, 16'b00000_???_???_10000,
      16'b00000_???_???_10001, 16'b00000_???_???_10110,
      16'b00000_???_???_10111,
      16'b00100_???_????????, 16'b00110_???_????????,
      16'b00111_???_????????, 16'b01000_???_????????,
      16'b01001_???_????????: wr = 1'b1;
      default:                 wr = 1'b0;
    endcase
    return wr;
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/risc16b_reg_file.sv
// Eight 16-bit general registers: two combinational read ports, one write port.
module risc16b_reg_file
  import risc16b_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ra_addr,
  output logic [15:0] ra_data,
  input  logic [2:0]  rb_addr,
  output logic [15:0] rb_data,
  input  logic        we,
  input  logic [2:0]  wa,
  input  logic [15:0] wd
);

  logic [15:0] registers [0:7];

  assign ra_data = registers[ra_addr];
  assign rb_data = registers[rb_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        registers[i] <= 16'h0000;
      end
    end else if (we) begin
      registers[wa] <= wd;
    end
  end

endmodule

// File: rtl/risc16b_core.sv
// risc16b core: IF / ID / EX / WB in-order pipeline with full forwarding into ID,
// loads and stores resolved in EX against combinational external memory.
module risc16b_core
  import risc16b_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] i_addr,
  output logic        i_oe,
  input  logic [15:0] i_din,
  output logic [15:0] d_addr,
  output logic        d_oe,
  input  logic [15:0] d_din,
  output logic [15:0] d_dout,
  output logic [1:0]  d_we
);

  logic [15:0] if_pc_q, if_pc_d;
  logic [15:0] if_ir_q, if_ir_d;
  logic [15:0] if_ir_pc_q, if_ir_pc_d;
  logic [15:0] id_op1_q, id_op1_d;
  logic [15:0] id_op2_q, id_op2_d;
  logic [7:0]  id_imm_q, id_imm_d;
  logic [15:0] id_pc_q, id_pc_d;
  logic [15:0] id_ir_q, id_ir_d;
  logic [15:0] ex_result_q, ex_result_d;
  logic [15:0] ex_ir_q, ex_ir_d;

  logic [15:0] if_pc;
  insn_t       id_insn;
  insn_t       ex_insn;
  logic [15:0] rf_a_data;
  logic [15:0] rf_b_data;
  logic        ex_fwd;
  logic        wb_we;
  logic [15:0] ex_imm_sx;
  logic [15:0] br_target;
  logic        br_taken;

  assign if_pc   = if_pc_q;
  assign i_addr  = if_pc_q;
  assign i_oe    = 1'b1;
  assign d_addr  = id_op2_q;
  assign id_insn = insn_t'(if_ir_q);
  assign ex_insn = insn_t'(id_ir_q);
  assign wb_we   = writes_reg(ex_ir_q);

  risc16b_reg_file reg_file_inst (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (id_insn.rd),
    .ra_data (rf_a_data),
    .rb_addr (id_insn.rs),
    .rb_data (rf_b_data),
    .we      (wb_we),
    .wa      (ex_ir_q[10:8]),
    .wd      (ex_result_q)
  );

  // Operand fetch: the EX result being computed now wins over the WB result,
  // which wins over the register file, so back-to-back dependencies never stall.
  always_comb begin
    ex_fwd = writes_reg(id_ir_q);
    if (ex_fwd && (ex_insn.rd == id_insn.rd)) begin
      id_op1_d = ex_result_d;
    end else if (wb_we && (ex_ir_q[10:8] == id_insn.rd)) begin
      id_op1_d = ex_result_q;
    end else begin
      id_op1_d = rf_a_data;
    end
    if (ex_fwd && (ex_insn.rd == id_insn.rs)) begin
      id_op2_d = ex_result_d;
    end else if (wb_we && (ex_ir_q[10:8] == id_insn.rs)) begin
      id_op2_d = ex_result_q;
    end else begin
      id_op2_d = rf_b_data;
    end
  end

  always_comb begin
    ex_imm_sx   = sext8(id_imm_q);
    br_target   = id_pc_q + 16'd2 + ex_imm_sx;
    ex_result_d = 16'h0000;
    d_we        = 2'b00;
    d_oe        = 1'b0;
    d_dout      = id_op1_q;
    br_taken    = 1'b0;
    case (ex_insn.op)
      OP_R: begin
        case (ex_insn.func)
          F_MV:  ex_result_d = id_op2_q;
          F_NOT: ex_result_d = ~id_op2_q;
          F_XOR: ex_result_d = id_op1_q ^ id_op2_q;
          F_ADD: ex_result_d = id_op1_q + id_op2_q;
          F_SUB: ex_result_d = id_op1_q - id_op2_q;
          F_SL8: ex_result_d = {id_op2_q[7:0], 8'h00};
          F_SR8: ex_result_d = {8'h00, id_op2_q[15:8]};
          F_SL:  ex_result_d = {id_op2_q[14:0], 1'b0};
          F_SR:  ex_result_d = {1'b0, id_op2_q[15:1]};
          F_AND: ex_result_d = id_op1_q & id_op2_q;
          F_OR:  ex_result_d = id_op1_q | id_op2_q;
          F_ST:  d_we = 2'b11;
          F_SB: begin
            // d_we[0] strobes the even (high) byte lane, d_we[1] the odd lane.
            d_dout = {id_op1_q[7:0], id_op1_q[7:0]};
            d_we   = id_op2_q[0] ? 2'b10 : 2'b01;
          end
          F_LD: begin
            d_oe        = 1'b1;
            ex_result_d = d_din;
          end
          F_LBU: begin
            d_oe        = 1'b1;
            ex_result_d = id_op2_q[0] ? {8'h00, d_din[7:0]} : {8'h00, d_din[15:8]};
          end
          default: ex_result_d = 16'h0000;
        endcase
      end
      OP_ADDI: ex_result_d = id_op1_q + ex_imm_sx;
      OP_ANDI: ex_result_d = id_op1_q & {8'h00, id_imm_q};
      OP_ORI:  ex_result_d = id_op1_q | {8'h00, id_imm_q};
      OP_LLI:  ex_result_d = {8'h00, id_imm_q};
      OP_LUI:  ex_result_d = {id_imm_q, 8'h00};
      OP_BNEZ: br_taken = (id_op1_q != 16'h0000);
      OP_BEQZ: br_taken = (id_op1_q == 16'h0000);
      OP_BMI:  br_taken = id_op1_q[15];
      OP_BPL:  br_taken = ~id_op1_q[15];
      OP_J:    br_taken = 1'b1;
      default: ex_result_d = 16'h0000;
    endcase
  end

  // A taken branch redirects fetch and kills the two younger instructions.
  always_comb begin
    if (br_taken) begin
      if_pc_d = br_target;
      if_ir_d = NOP_INSN;
      id_ir_d = NOP_INSN;
    end else begin
      if_pc_d = if_pc_q + 16'd2;
      if_ir_d = i_din;
      id_ir_d = id_insn;
    end
    if_ir_pc_d = if_pc_q;
    id_pc_d    = if_ir_pc_q;
    id_imm_d   = {id_insn.rs, id_insn.func};
    ex_ir_d    = ex_insn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_pc_q     <= RESET_PC;
      if_ir_q     <= NOP_INSN;
      if_ir_pc_q  <= RESET_PC;
      id_op1_q    <= 16'h0000;
      id_op2_q    <= 16'h0000;
      id_imm_q    <= 8'h00;
      id_pc_q     <= RESET_PC;
      id_ir_q     <= NOP_INSN;
      ex_result_q <= 16'h0000;
      ex_ir_q     <= NOP_INSN;
    end else begin
      if_pc_q     <= if_pc_d;
      if_ir_q     <= if_ir_d;
      if_ir_pc_q  <= if_ir_pc_d;
      id_op1_q    <= id_op1_d;
      id_op2_q    <= id_op2_d;
      id_imm_q    <= id_imm_d;
      id_pc_q     <= id_pc_d;
      id_ir_q     <= id_ir_d;
      ex_result_q <= ex_result_d;
      ex_ir_q     <= ex_ir_d;
    end
  end

endmodule

// File: tb/tb_risc16b_core.sv
// Directed program for risc16b_core with hand-computed register, bus and PC expectations.
module tb_risc16b_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_addr;
  logic        i_oe;
  logic [15:0] i_din;
  logic [15:0] d_addr;
  logic        d_oe;
  logic [15:0] d_din;
  logic [15:0] d_dout;
  logic [1:0]  d_we;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] imem [0:31];
  logic [7:0]  dmem [0:65535];

  logic [15:0] exp_st_addr [0:2];
  logic [1:0]  exp_st_we   [0:2];
  logic [15:0] exp_st_data [0:2];
  logic [15:0] exp_ld_addr [0:1];
  logic [15:0] exp_reg     [0:7];
  int          st_idx;
  int          ld_idx;
  int          waited;

  risc16b_core dut (
    .clk    (clk),
    .rst    (rst),
    .i_addr (i_addr),
    .i_oe   (i_oe),
    .i_din  (i_din),
    .d_addr (d_addr),
    .d_oe   (d_oe),
    .d_din  (d_din),
    .d_dout (d_dout),
    .d_we   (d_we)
  );

  always #5 clk = ~clk;

  assign i_din = (i_addr[15:6] == 10'h000) ? imem[i_addr[5:1]] : 16'h0000;
  assign d_din = {dmem[{d_addr[15:1], 1'b0}], dmem[{d_addr[15:1], 1'b1}]};

  always @(posedge clk) begin
    if (d_we[0]) dmem[{d_addr[15:1], 1'b0}] <= d_dout[15:8];
    if (d_we[1]) dmem[{d_addr[15:1], 1'b1}] <= d_dout[7:0];
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) dmem[i] = 8'h00;
    for (int i = 0; i < 32; i++) imem[i] = 16'h0000;
    imem[0]  = 16'h4105; // 00 LLI  r1,05
    imem[1]  = 16'h2103; // 02 ADDI r1,03
    imem[2]  = 16'h0224; // 04 ADD  r2,r1
    imem[3]  = 16'h4BC0; // 06 LUI  r3,C0
    imem[4]  = 16'h0174; // 08 ST   r1,(r3)
    imem[5]  = 16'h0476; // 0A LD   r4,(r3)
    imem[6]  = 16'h4501; // 0C LLI  r5,01
    imem[7]  = 16'h0571; // 0E OR   r5,r3
    imem[8]  = 16'h01B5; // 10 SB   r1,(r5)
    imem[9]  = 16'h06B7; // 12 LBU  r6,(r5)
    imem[10] = 16'h4B7F; // 14 LUI  r3,7F
    imem[11] = 16'h0174; // 16 ST   r1,(r3)
    imem[12] = 16'h22FD; // 18 ADDI r2,-3   -> 0005
    imem[13] = 16'h0248; // 1A SL8  r2,r2   -> 0500
    imem[14] = 16'h8002; // 1C BNEZ r0,+2   (not taken)
    imem[15] = 16'h0223; // 1E XOR  r2,r1   -> 0508
    imem[16] = 16'h8804; // 20 BEQZ r0,+4   -> 0026
    imem[17] = 16'h2701; // 22 ADDI r7,01   (squashed)
    imem[18] = 16'h2701; // 24 ADDI r7,01   (squashed)
    imem[19] = 16'hC0FE; // 26 J    -2      (self loop)

    exp_st_addr[0] = 16'hC000; exp_st_we[0] = 2'b11; exp_st_data[0] = 16'h0008;
    exp_st_addr[1] = 16'hC001; exp_st_we[1] = 2'b10; exp_st_data[1] = 16'h0808;
    exp_st_addr[2] = 16'h7F00; exp_st_we[2] = 2'b11; exp_st_data[2] = 16'h0008;
    exp_ld_addr[0] = 16'hC000;
    exp_ld_addr[1] = 16'hC001;
    exp_reg[0] = 16'h0000; exp_reg[1] = 16'h0008; exp_reg[2] = 16'h0508; exp_reg[3] = 16'h7F00;
    exp_reg[4] = 16'h0008; exp_reg[5] = 16'hC001; exp_reg[6] = 16'h0008; exp_reg[7] = 16'h0000;

    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_i_addr", i_addr, 16'h0000);
    check_val("rst_d_we", {14'h0000, d_we}, 16'h0000);
    check_val("rst_d_oe", {15'h0000, d_oe}, 16'h0000);
    check_val("rst_i_oe", {15'h0000, i_oe}, 16'h0001);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("rst_r%0d", i), dut.reg_file_inst.registers[i], 16'h0000);

    rst = 1'b0;
    #1 check_val("fetch_0", i_addr, 16'h0000);
    @(negedge clk);
    check_val("fetch_1", i_addr, 16'h0002);
    @(negedge clk);
    check_val("fetch_2", i_addr, 16'h0004);
    check_val("if_pc_2", dut.if_pc, 16'h0004);

    st_idx = 0;
    ld_idx = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (d_we != 2'b00) begin
        if (st_idx < 3) begin
          check_val($sformatf("st%0d_addr", st_idx), d_addr, exp_st_addr[st_idx]);
          check_val($sformatf("st%0d_we", st_idx), {14'h0000, d_we}, {14'h0000, exp_st_we[st_idx]});
          check_val($sformatf("st%0d_dout", st_idx), d_dout, exp_st_data[st_idx]);
          st_idx++;
        end else begin
          check_val("extra_store", {14'h0000, d_we}, 16'h0000);
        end
      end
      if (d_oe) begin
        if (ld_idx < 2) begin
          check_val($sformatf("ld%0d_addr", ld_idx), d_addr, exp_ld_addr[ld_idx]);
          ld_idx++;
        end else begin
          check_val("extra_load", {15'h0000, d_oe}, 16'h0000);
        end
      end
    end
    check_val("store_count", st_idx[15:0], 16'd3);
    check_val("load_count", ld_idx[15:0], 16'd2);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("final_r%0d", i), dut.reg_file_inst.registers[i], exp_reg[i]);
    check_val("mem_c000", {dmem[16'hC000], dmem[16'hC001]}, 16'h0008);
    check_val("mem_7f00", {dmem[16'h7F00], dmem[16'h7F01]}, 16'h0008);

    waited = 0;
    while (i_addr !== 16'h0026 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check_val("loop_entry", i_addr, 16'h0026);
    @(negedge clk);
    check_val("loop_plus1", i_addr, 16'h0028);
    @(negedge clk);
    @(negedge clk);
    check_val("loop_again", i_addr, 16'h0026);
    repeat (3) @(negedge clk);
    check_val("loop_third", i_addr, 16'h0026);
    check_val("loop_no_we", {14'h0000, d_we}, 16'h0000);

    #2 rst = 1'b1;
    #1;
    check_val("midrst_i_addr", i_addr, 16'h0000);
    check_val("midrst_r2", dut.reg_file_inst.registers[2], 16'h0000);
    check_val("midrst_r5", dut.reg_file_inst.registers[5], 16'h0000);
    check_val("midrst_d_we", {14'h0000, d_we}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
